// File: rtl/burst_sram_if.sv
// Bundle of request, write-beat, read-beat and single-beat SRAM signals for burst_sram_ctrl.
// slave is the controller's view; master is the requester/SRAM side.
interface burst_sram_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
);
    // valid/ready: a request or write beat transfers on a rising edge where both are high;
    // rd_valid carries no backpressure and must be consumed in the cycle it is high.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_data, wr_valid, mem_rdata,
        output req_ready, wr_ready, rd_data, rd_valid, done, err,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_data, wr_valid, mem_rdata,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err,
               mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/burst_sram_ctrl.sv
// Burst-to-single-beat SRAM controller: splits write/read bursts into one access per cycle.
// Optional macro BURST_SRAM_CTRL_BOUND_CHECK_EN rejects bursts that would cross the top address.
module burst_sram_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    burst_sram_if.slave bus,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  eff_len;
    logic              req_ready_q;
    logic              done_q;
    logic              rd_pending;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              accept;
    logic              reject;
    logic              wr_beat;
    logic              rd_issue;

    // req_ready_q tracks state == IDLE, so it doubles as the acceptance qualifier.
    assign accept   = bus.req_valid && req_ready_q;
    assign wr_beat  = (state == WRITE) && bus.wr_valid;
    assign rd_issue = (state == READ);

    always_comb begin
        eff_len = bus.req_len;
        if (int'(bus.req_len) > DEPTH) begin
            eff_len = LEN_W'(DEPTH);
        end
    end

`ifdef BURST_SRAM_CTRL_BOUND_CHECK_EN
    logic err_q;
    assign reject  = accept && ((int'(bus.req_addr) + int'(bus.req_len)) > DEPTH);
    assign bus.err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    // SRAM port is combinational so a write beat lands in the cycle it is accepted.
    assign bus.wr_ready  = wr_beat;
    assign bus.mem_cs    = wr_beat || rd_issue;
    assign bus.mem_we    = wr_beat;
    assign bus.mem_addr  = (wr_beat || rd_issue) ? cur_addr : '0;
    assign bus.mem_wdata = wr_beat ? bus.wr_data : '0;

    assign bus.req_ready = req_ready_q;
    assign bus.done      = done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            beats_left  <= '0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            rd_pending  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_pending <= rd_issue;
            rd_valid_q <= rd_pending;
            if (rd_pending) begin
                rd_data_q <= bus.mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (accept && !reject) begin
                        cur_addr    <= bus.req_addr;
                        beats_left  <= eff_len;
                        req_ready_q <= 1'b0;
                        if (eff_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= bus.req_we ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        beats_left <= beats_left - LEN_W'(1);
                        if (beats_left == LEN_W'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    cur_addr   <= cur_addr + ADDR_W'(1);
                    beats_left <= beats_left - LEN_W'(1);
                    if (beats_left == LEN_W'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_sram_ctrl.sv
// Self-checking bench for burst_sram_ctrl: directed scenarios plus random bursts
// checked against a memory-array reference model and a per-burst scoreboard.
module tb_burst_sram_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 5;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef BURST_SRAM_CTRL_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    burst_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    burst_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM environment: registered read data, write on the edge
    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    typedef struct { bit we; int addr; int data; int cyc; } acc_t;
    acc_t acc_q[$];
    int   rd_data_q[$];
    int   rd_cyc_q[$];
    int   done_cyc_q[$];
    int   err_cyc_q[$];
    int   prot_viol = 0;
    logic [DATA_W-1:0] wdata_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.mem_cs) acc_q.push_back('{bus.mem_we, int'(bus.mem_addr), int'(bus.mem_wdata), cyc});
        if (bus.rd_valid) begin
            rd_data_q.push_back(int'(bus.rd_data));
            rd_cyc_q.push_back(cyc);
        end
        if (bus.done) done_cyc_q.push_back(cyc);
        if (bus.err) err_cyc_q.push_back(cyc);
        if (bus.mem_we && !bus.mem_cs) prot_viol++;
        if (bus.done && bus.req_ready) prot_viol++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_mon();
        acc_q.delete();
        rd_data_q.delete();
        rd_cyc_q.delete();
        done_cyc_q.delete();
        err_cyc_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        check("req_ready_idle", bus.req_ready, 1);
    endtask

    // Called at posedge+1. dbase >= 0 gives data dbase+i, otherwise random data.
    task automatic run_burst(input bit we, input int addr, input int len,
                             input int stall_at, input int stall_n, input int dbase);
        int  eff, n, a, acc_cyc, idx, stall_left, budget, extra, exp_done, exp_err;
        bit  reject;
        eff    = (len > DEPTH) ? DEPTH : len;
        reject = BOUND && (addr + len > DEPTH);
        n      = reject ? 0 : eff;
        extra  = (we && stall_at < n) ? stall_n : 0;
        wdata_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            wdata_q.push_back((dbase >= 0) ? DATA_W'(dbase + i) : DATA_W'($urandom));
        end
        for (int i = 0; i < n; i++) begin
            a = (addr + i) % DEPTH;
            if (we) ref_mem[a] = wdata_q[i];
            else exp_q.push_back(ref_mem[a]);
        end

        wait_ready();
        clear_mon();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_len   = LEN_W'(len);
        tick();
        bus.req_valid = 1'b0;
        acc_cyc = cyc;

        if (we) begin
            idx = 0;
            stall_left = stall_n;
            budget = 0;
            while (idx < n && budget < 100) begin
                if (idx == stall_at && stall_left > 0) begin
                    bus.wr_valid = 1'b0;
                    stall_left--;
                end else begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = wdata_q[idx];
                end
                @(negedge clk);
                if (bus.wr_ready) idx++;
                tick();
                budget++;
            end
            bus.wr_valid = 1'b0;
            check("wr_beats_taken", idx, n);
        end

        budget = 0;
        while (done_cyc_q.size() == 0 && err_cyc_q.size() == 0 && budget < 60) begin
            tick();
            budget++;
        end
        repeat (3) tick();

        if (reject) exp_done = -1;
        else if (n == 0) exp_done = acc_cyc;
        else if (we) exp_done = acc_cyc + n + extra;
        else exp_done = acc_cyc + n + 1;
        exp_err = reject ? acc_cyc : -1;
        check("done_count", done_cyc_q.size(), reject ? 0 : 1);
        check("done_cycle", (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, exp_done);
        check("err_count", err_cyc_q.size(), reject ? 1 : 0);
        check("err_cycle", (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, exp_err);

        check("acc_count", acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            check("acc_we", acc_q[i].we, we);
            check("acc_addr", acc_q[i].addr, (addr + i) % DEPTH);
            check("acc_cycle", acc_q[i].cyc, acc_cyc + i + ((we && i >= stall_at) ? extra : 0));
            if (we) check("acc_wdata", acc_q[i].data, wdata_q[i]);
        end

        check("rd_count", rd_data_q.size(), exp_q.size());
        for (int i = 0; i < rd_data_q.size() && i < exp_q.size(); i++) begin
            check("rd_data", rd_data_q[i], exp_q[i]);
            check("rd_latency", rd_cyc_q[i], acc_cyc + i + 2);
        end
    endtask

    task automatic reset_mid_read();
        wait_ready();
        clear_mon();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = ADDR_W'(3);
        bus.req_len   = LEN_W'(6);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("third_beat_cs", bus.mem_cs, 1);
        check("third_beat_addr", bus.mem_addr, 5);
        check("first_rd_before_rst", bus.rd_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_abort_cs", bus.mem_cs, 0);
        check("rst_abort_rd_valid", bus.rd_valid, 0);
        check("rst_abort_addr", bus.mem_addr, 0);
        check("rst_abort_done", bus.done, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_mon();
        tick();
        check("ready_after_release", bus.req_ready, 1);
        repeat (4) tick();
        check("no_stray_cs", acc_q.size(), 0);
        check("no_stray_rd", rd_data_q.size(), 0);
        check("no_stray_done", done_cyc_q.size(), 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = DATA_W'($urandom);
            ref_mem[i] = sram[i];
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_cs", bus.mem_cs, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rd_data", bus.rd_data, 0);
        rst_n = 1'b1;
        tick();
        check("ready_first_edge", bus.req_ready, 1);

        run_burst(1'b1, 2, 4, 99, 0, 'hA0);
        run_burst(1'b0, 2, 4, 99, 0, -1);
        run_burst(1'b1, 1, 3, 1, 2, -1);
        run_burst(1'b0, 1, 3, 99, 0, -1);
        run_burst(1'b0, 14, 4, 99, 0, -1);
        run_burst(1'b1, 14, 4, 0, 1, -1);
        run_burst(1'b1, 5, 0, 99, 0, -1);
        run_burst(1'b0, 9, 0, 99, 0, -1);
        run_burst(1'b1, 0, 20, 99, 0, -1);
        run_burst(1'b0, 0, 16, 99, 0, -1);
        run_burst(1'b0, 7, 16, 99, 0, -1);
        run_burst(1'b0, 15, 1, 99, 0, -1);

        reset_mid_read();
        run_burst(1'b0, 3, 6, 99, 0, -1);

        for (int k = 0; k < 40; k++) begin
            run_burst(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, 20), $urandom_range(0, 6), $urandom_range(0, 3), -1);
        end

        check("protocol_violations", prot_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/burst_sram_ctrl.md
BURST_SRAM_CTRL -- requirements
Module: burst_sram_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, SRAM address width; DATA_W, default 8, data width; LEN_W, default 5, burst length width (lengths 0..16).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  burst request present; req_ready  out  1  high only in IDLE.
REQ-006 req_we  in  1  1=write burst, 0=read burst; req_addr  in  ADDR_W  start address; req_len  in  LEN_W  beat count.
REQ-007 wr_data  in  DATA_W  write beat; wr_valid  in  1  beat present; wr_ready  out  1  beat accepted this cycle.
REQ-008 rd_data  out  DATA_W  read beat; rd_valid  out  1  rd_data valid this cycle (no backpressure).
REQ-009 done  out  1  one-cycle pulse at burst end; err  out  1  one-cycle pulse on rejected request (macro-dependent).
REQ-010 mem_cs, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: single-beat SRAM port (burst length 1 per access); mem_rdata  in  DATA_W: registered SRAM output, valid one cycle after a read access.

Function
REQ-011 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, DONE.
REQ-012 IDLE: a request SHALL be accepted on req_valid&req_ready; req_we, req_addr, and req_len SHALL be latched into cur_addr and beats_left.
REQ-013 req_len=0 SHALL go IDLE->DONE with no memory access.
REQ-014 Otherwise, a write request SHALL go to WRITE and a read request SHALL go to READ.
REQ-015 WRITE: wr_ready SHALL equal wr_valid.
REQ-016 On each accepted beat, the block SHALL drive mem_cs=1, mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data combinationally in the same cycle; cur_addr SHALL increment and beats_left SHALL decrement.
REQ-017 In WRITE, wr_valid=0 SHALL give mem_cs=0 (stall, no state change); the last beat SHALL move the FSM to DONE.
REQ-018 READ: each cycle SHALL issue mem_cs=1, mem_we=0, mem_addr=cur_addr, with one access per cycle (no gaps), incrementing cur_addr; after the last issue the FSM SHALL go to DRAIN.
REQ-019 rd_valid/rd_data SHALL be registered copies of (a read issued last cycle)/mem_rdata, giving a latency of 2 cycles from issue to rd_valid.
REQ-020 DRAIN SHALL last one cycle (last beat returns), then go to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; req_ready SHALL be low in DONE.
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_W (15 -> 0) unless REQ-030 applies.
REQ-023 req_len > 2^ADDR_W SHALL be clamped to 2^ADDR_W beats.
REQ-024 Outside WRITE and READ, mem_cs SHALL be 0; mem_we SHALL be 0 whenever mem_cs is 0.
REQ-025 A read burst SHALL yield exactly N rd_valid pulses, in address order, for an N-beat request.

Reset
REQ-026 On rst_n=0 the block SHALL immediately enter IDLE, aborting any burst; no further mem_cs or rd_valid for the aborted burst.
REQ-027 During reset: mem_cs, mem_we, wr_ready, rd_valid, done, err SHALL be 0; mem_addr, mem_wdata, rd_data SHALL be 0.
REQ-028 After rst_n rises, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-029 Macro BURST_SRAM_CTRL_BOUND_CHECK_EN SHALL select boundary handling.
REQ-030 Defined: a request with req_addr+req_len > 2^ADDR_W SHALL be rejected: err pulses one cycle after acceptance, no memory access, no done, FSM returns to IDLE.
REQ-031 Undefined: err SHALL be tied 0, and crossing bursts SHALL wrap per REQ-022.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
REQ-033 Write addr=2, len=4, data A0..A3, wr_valid continuous -> mem writes 2:A0, 3:A1, 4:A2, 5:A3 on 4 consecutive cycles; done 1 cycle after the last write.
REQ-034 Read back addr=2, len=4 -> rd_valid on 4 consecutive cycles with A0,A1,A2,A3; first rd_valid 2 cycles after the first mem_cs.
REQ-035 Write addr=1, len=3, wr_valid low on the second beat for 2 cycles -> mem_cs low for those 2 cycles; addresses 1,2,3 written in order.
REQ-036 Read addr=14, len=4 -> without the macro, addresses 14,15,0,1 are read; with the macro, err pulses and there is no mem_cs and no done.
REQ-037 req_len=0 -> no mem_cs; done pulses 1 cycle after acceptance.
REQ-038 rst_n low during the third beat of a 6-beat read -> mem_cs and rd_valid go 0 immediately; req_ready=1 after release; a new request completes normally.
